useq_sequencer: RTL



---
 rtl/useq_pkg.sv | 47 ++++
 rtl/useq_stack.sv | 57 +++++
 rtl/useq_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/useq_pkg.sv
// Shared definitions for the microprogram sequencer: sequencing codes, FSM
// states and microword field offsets derived from the block parameters.
package useq_pkg;

    typedef enum logic [2:0] {
        SEQ_INC  = 3'b000,
        SEQ_JMP  = 3'b001,
        SEQ_BRT  = 3'b010,
        SEQ_BRF  = 3'b011,
        SEQ_MAP  = 3'b100,
        SEQ_CALL = 3'b101,
        SEQ_RET  = 3'b110,
        SEQ_HALT = 3'b111
    } seq_e;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_LATCH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    typedef enum logic [1:0] {
        FETCH = ST_FETCH,
        LATCH = ST_LATCH,
        HALT  = ST_HALT
    } state_e;

    // Index width for n items, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cond_w(input int ncond);
        return idx_w(ncond);
    endfunction

    function automatic int seq_lsb(input int aw);
        return aw;
    endfunction

    function automatic int csel_lsb(input int aw);
        return aw + 3;
    endfunction

    function automatic int ctrl_lsb(input int aw, input int ncond);
        return aw + 3 + cond_w(ncond);
    endfunction

endpackage

// File: rtl/useq_stack.sv
// Return-address LIFO for the sequencer. Only the pointer is reset; the
// storage contents are meaningless until written by a push.
module useq_stack
    import useq_pkg::*;
#(
    parameter int AW = 8,
    parameter int SD = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] top
);

    localparam int PW = $clog2(SD + 1);
    localparam int IW = idx_w(SD);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] mem_q [SD];
    logic [IW-1:0] top_idx;

    assign full    = (ptr_q == PW'(SD));
    assign empty   = (ptr_q == '0);
    assign top_idx = IW'(ptr_q - PW'(1));
    assign top     = mem_q[top_idx];

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        ptr_d = ptr_q;
        if (push && !full) begin
            ptr_d = ptr_q + PW'(1);
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PW'(1);
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // NOTE: the storage array has no reset; the pointer alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[ptr_q[IW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/useq_sequencer.sv
// Microprogram sequencer: addresses the synchronous microprogram ROM, latches
// each returned microword into the UIR and computes the next micro-PC.
module useq_sequencer
    import useq_pkg::*;
#(
    parameter int              AW         = 8,
    parameter int              UW         = 24,
    parameter int              NCOND      = 4,
    parameter int              SD         = 4,
    parameter logic [AW-1:0]   RESET_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NCOND-1:0] cond,
    input  logic [AW-1:0]    map_addr,
    output logic [AW-1:0]    rom_addr,
    input  logic [UW-1:0]    rom_q,
    output logic [UW-1:0]    uir,
    output logic             uir_valid,
    output logic [AW-1:0]    upc,
    output logic             halted,
    output logic             stk_err
);

    localparam int CW   = cond_w(NCOND);
    localparam int SLSB = seq_lsb(AW);
    localparam int CLSB = csel_lsb(AW);

    state_e        state_q, state_d;
    logic [AW-1:0] upc_q, upc_d;
    logic [UW-1:0] uir_q, uir_d;
    logic          uir_valid_q, uir_valid_d;
    logic          halted_q, halted_d;
    logic          stk_err_q, stk_err_d;

    logic [AW-1:0] na, upc_inc, next_upc, stk_top;
    logic [CW-1:0] csel;
    seq_e          seq;
    logic          step, push, pop, stk_fault, stk_full, stk_empty;

    // Fields are decoded straight from the ROM output, which is the word
    // about to be latched.
    assign na      = rom_q[AW-1:0];
    assign seq     = seq_e'(rom_q[SLSB +: 3]);
    assign csel    = rom_q[CLSB +: CW];
    assign upc_inc = upc_q + AW'(1);
    assign step    = en && (state_q == LATCH);

    always_comb begin
        next_upc  = upc_inc;
        push      = 1'b0;
        pop       = 1'b0;
        stk_fault = 1'b0;
        case (seq)
            SEQ_INC:  next_upc = upc_inc;
            SEQ_JMP:  next_upc = na;
            SEQ_BRT:  if (cond[csel])  next_upc = na;
            SEQ_BRF:  if (!cond[csel]) next_upc = na;
            SEQ_MAP:  next_upc = map_addr;
            SEQ_CALL: begin
                next_upc = na;
                if (stk_full) stk_fault = 1'b1;
                else          push      = step;
            end
            SEQ_RET: begin
                if (stk_empty) begin
                    stk_fault = 1'b1;
                end else begin
                    next_upc = stk_top;
                    pop      = step;
                end
            end
            SEQ_HALT: next_upc = upc_q;
            default:  next_upc = upc_inc;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        upc_d       = upc_q;
        uir_d       = uir_q;
        uir_valid_d = 1'b0;
        halted_d    = halted_q;
        stk_err_d   = stk_err_q;
        if (en) begin
            case (state_q)
                FETCH: state_d = LATCH;
                LATCH: begin
                    uir_d       = rom_q;
                    uir_valid_d = 1'b1;
                    upc_d       = next_upc;
                    stk_err_d   = stk_err_q | stk_fault;
                    if (seq == SEQ_HALT) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            upc_q       <= RESET_ADDR;
            uir_q       <= '0;
            uir_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            stk_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            upc_q       <= upc_d;
            uir_q       <= uir_d;
            uir_valid_q <= uir_valid_d;
            halted_q    <= halted_d;
            stk_err_q   <= stk_err_d;
        end
    end

    useq_stack #(
        .AW (AW),
        .SD (SD)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (upc_inc),
        .full      (stk_full),
        .empty     (stk_empty),
        .top       (stk_top)
    );

    assign rom_addr  = upc_q;
    assign upc       = upc_q;
    assign uir       = uir_q;
    assign uir_valid = uir_valid_q;
    assign halted    = halted_q;
    assign stk_err   = stk_err_q;

endmodule
